// File: rtl/sync_fifo_pkg.sv
// Shared types and configuration checks for the flagged synchronous FIFO.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Legal configuration: power-of-two depth of at least 2, thresholds inside the occupancy range.
  function automatic bit fifo_cfg_ok(int width, int depth, int afull_thr, int aempty_thr);
    return (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (afull_thr >= 1) && (afull_thr <= depth) &&
           (aempty_thr >= 0) && (aempty_thr <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage: synchronous write port, asynchronous read port; no reset.
// Latency: write lands on the clock edge, read is combinational; no flow control of its own.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Latency: STD data one edge after rd_en, FWFT word shown right after its write; full rejects writes, empty rejects reads.
module sync_fifo_flagged
  import sync_fifo_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter int         DEPTH      = 16,
  parameter int         AFULL_THR  = DEPTH - 2,
  parameter int         AEMPTY_THR = 2,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       d_in,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       d_out,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (!fifo_cfg_ok(WIDTH, DEPTH, AFULL_THR, AEMPTY_THR)) begin : g_bad_cfg
    $error("sync_fifo_flagged: illegal WIDTH/DEPTH/threshold configuration");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             wa;
  logic             ra;

  assign wa = wr_en && !full;
  assign ra = rd_en && !empty;

  // Count is kept separately from the pointers so all DEPTH slots are usable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + 1'b1;
      if (ra) rd_ptr <= rd_ptr + 1'b1;
      case ({wa, ra})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_en && !wa;
      underflow <= rd_en && !ra;
    end
  end

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AFULL_THR));
  assign almost_empty = (count <= CW'(AEMPTY_THR));

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wa),
    .waddr (wr_ptr),
    .wdata (d_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [WIDTH-1:0] d_out_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        d_out_q <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= ra;
        if (ra) d_out_q <= mem_rdata;
      end
    end

    assign d_out = d_out_q;
    assign valid = valid_q;
  end else begin : g_fwft
    // Head of queue is presented directly; rd_en acknowledges and pops it.
    assign d_out = mem_rdata;
    assign valid = !empty;
  end

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Randomized bench for sync_fifo_flagged: STD and FWFT instances checked against a queue model.
module tb_sync_fifo_flagged;
  import sync_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] d_in = '0;
  logic [7:0] d_out;
  logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_wr = 1'b0, f_rd = 1'b0;
  logic [7:0] f_din = '0;
  logic [7:0] f_dout;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] exp_dout = '0;
  logic       exp_valid = 1'b0, exp_ovf = 1'b0, exp_udf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_flagged #(.WIDTH(8), .DEPTH(DEPTH), .AFULL_THR(14), .AEMPTY_THR(2), .MODE(FIFO_STD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en), .d_out(d_out), .valid(valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow));

  sync_fifo_flagged #(.WIDTH(8), .DEPTH(DEPTH), .AFULL_THR(14), .AEMPTY_THR(2), .MODE(FIFO_FWFT)) dut_f (
    .clk(clk), .rst(rst), .wr_en(f_wr), .d_in(f_din), .rd_en(f_rd), .d_out(f_dout), .valid(f_valid),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_udf));

  // One clock of the STD instance; the model follows the accept/reject rules on pre-edge occupancy.
  task automatic step(input logic we, input logic re, input logic [7:0] din);
    bit wa, ra;
    wr_en = we; rd_en = re; d_in = din;
    @(posedge clk);
    wa = we && (q.size() < DEPTH);
    ra = re && (q.size() > 0);
    exp_ovf   = we && !wa;
    exp_udf   = re && !ra;
    exp_valid = ra;
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(din);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; f_wr = 1'b0; f_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    exp_dout = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got e=%b ae=%b want 1 1", empty, almost_empty); end
    total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_full: got f=%b af=%b want 0 0", full, almost_full); end
    total++; if (valid !== 1'b0 || d_out !== 8'h00) begin bad++; $display("FAIL reset_out: got v=%b d=%0h want 0 0", valid, d_out); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err: got o=%b u=%b want 0 0", overflow, underflow); end
    total++; if (f_valid !== 1'b0 || f_empty !== 1'b1) begin bad++; $display("FAIL reset_fwft: got v=%b e=%b want 0 1", f_valid, f_empty); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      total++; if (count !== 5'(q.size())) begin bad++; $display("FAIL fill_count: got %0d want %0d", count, q.size()); end
      total++; if (almost_full !== (q.size() >= 14)) begin bad++; $display("FAIL fill_afull: got %b at count %0d", almost_full, q.size()); end
      total++; if (full !== (q.size() == DEPTH)) begin bad++; $display("FAIL fill_full: got %b at count %0d", full, q.size()); end
    end
    step(1'b1, 1'b0, 8'h77);
    total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL overflow_pulse: got o=%b c=%0d want 1 16", overflow, count); end
    step(1'b0, 1'b0, 8'h00);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear: got %b want 0", overflow); end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      total++; if (d_out !== 8'(i) || valid !== 1'b1) begin bad++; $display("FAIL drain_data: got d=%0h v=%b want %0h 1", d_out, valid, i); end
      total++; if (almost_empty !== (q.size() <= 2)) begin bad++; $display("FAIL drain_aempty: got %b at count %0d", almost_empty, q.size()); end
    end
    step(1'b0, 1'b1, 8'h00);
    total++; if (underflow !== 1'b1 || valid !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL underflow_pulse: got u=%b v=%b c=%0d want 1 0 0", underflow, valid, count); end
    total++; if (d_out !== 8'h10) begin bad++; $display("FAIL hold_dout: got %0h want 10", d_out); end
    step(1'b0, 1'b0, 8'h00);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL underflow_clear: got %b want 0", underflow); end
  endtask

  task automatic test_simul_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom));
    step(1'b1, 1'b1, 8'hAA);
    total++; if (d_out !== exp_dout || valid !== 1'b1) begin bad++; $display("FAIL full_rw_data: got %0h want %0h", d_out, exp_dout); end
    total++; if (overflow !== 1'b1 || count !== 5'd15) begin bad++; $display("FAIL full_rw_flags: got o=%b c=%0d want 1 15", overflow, count); end
    while (q.size() > 0) begin
      step(1'b0, 1'b1, 8'h00);
      total++; if (d_out !== exp_dout) begin bad++; $display("FAIL full_rw_drain: got %0h want %0h", d_out, exp_dout); end
    end
  endtask

  task automatic test_simul_mid();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'($urandom));
      total++; if (count !== 5'd5 || overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL mid_count: got c=%0d o=%b u=%b want 5 0 0", count, overflow, underflow); end
      total++; if (d_out !== exp_dout || valid !== 1'b1) begin bad++; $display("FAIL mid_order: got %0h want %0h", d_out, exp_dout); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int bias = (i / 100) % 2 == 0 ? 70 : 30;
      step(($urandom_range(99) < bias), ($urandom_range(99) >= bias), 8'($urandom));
      total++;
      if (count !== 5'(q.size()) || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
          almost_full !== (q.size() >= 14) || almost_empty !== (q.size() <= 2)) begin
        bad++; $display("FAIL rand_flags: cyc %0d got c=%0d f=%b e=%b af=%b ae=%b want c=%0d", i, count, full, empty, almost_full, almost_empty, q.size());
      end
      total++;
      if (valid !== exp_valid || d_out !== exp_dout || overflow !== exp_ovf || underflow !== exp_udf) begin
        bad++; $display("FAIL rand_out: cyc %0d got v=%b d=%0h o=%b u=%b want %b %0h %b %b", i, valid, d_out, overflow, underflow, exp_valid, exp_dout, exp_ovf, exp_udf);
      end
    end
  endtask

  task automatic test_fwft();
    logic [7:0] qf[$];
    do_reset();
    f_din = 8'h5A; f_wr = 1'b1;
    @(posedge clk); #1 f_wr = 1'b0;
    total++; if (f_dout !== 8'h5A || f_valid !== 1'b1 || f_count !== 5'd1) begin bad++; $display("FAIL fwft_show: got d=%0h v=%b c=%0d want 5a 1 1", f_dout, f_valid, f_count); end
    @(posedge clk); #1;
    total++; if (f_dout !== 8'h5A || f_valid !== 1'b1) begin bad++; $display("FAIL fwft_hold: got d=%0h v=%b want 5a 1", f_dout, f_valid); end
    f_rd = 1'b1;
    @(posedge clk); #1 f_rd = 1'b0;
    total++; if (f_valid !== 1'b0 || f_empty !== 1'b1) begin bad++; $display("FAIL fwft_pop: got v=%b e=%b want 0 1", f_valid, f_empty); end
    for (int i = 0; i < 200; i++) begin
      bit wa, ra;
      f_wr = ($urandom_range(99) < 55); f_rd = ($urandom_range(99) < 45); f_din = 8'($urandom);
      @(posedge clk);
      wa = f_wr && (qf.size() < DEPTH);
      ra = f_rd && (qf.size() > 0);
      if (ra) void'(qf.pop_front());
      if (wa) qf.push_back(f_din);
      #1;
      total++; if (f_valid !== (qf.size() != 0) || f_count !== 5'(qf.size())) begin bad++; $display("FAIL fwft_rand_state: got v=%b c=%0d want c=%0d", f_valid, f_count, qf.size()); end
      if (qf.size() != 0) begin
        total++; if (f_dout !== qf[0]) begin bad++; $display("FAIL fwft_rand_head: got %0h want %0h", f_dout, qf[0]); end
      end
    end
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom));
    total++; if (count !== 5'd9) begin bad++; $display("FAIL mrst_pre: got %0d want 9", count); end
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; d_in = 8'hC3;
    @(posedge clk); #1;
    total++; if (count !== 5'd0 || empty !== 1'b1 || valid !== 1'b0 || d_out !== 8'h00) begin bad++; $display("FAIL mrst_state: got c=%0d e=%b v=%b d=%0h want 0 1 0 0", count, empty, valid, d_out); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL mrst_err: got o=%b u=%b want 0 0", overflow, underflow); end
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    q.delete(); exp_dout = '0; exp_valid = 1'b0;
    step(1'b0, 1'b0, 8'h00);
    total++; if (count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL mrst_after: got c=%0d o=%b u=%b want 0 0 0", count, overflow, underflow); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simul_full();
    test_simul_mid();
    test_random();
    test_fwft();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
